// File: rtl/datapath_wb.sv
// datapath_wb: writeback stage.
// Captures the MEM-stage result into the MEM/WB register, load-aligns and
// selects the writeback value, drives the register-file write port and
// supplies same-cycle bypass data to the two ID-stage read ports.
// Optional feature macro: INSTRET_COUNT_EN adds a retired-instruction
// counter on `instret`. Without it, `instret` is tied to zero.
module datapath_wb #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              wb_stall,
  input  logic              wb_flush,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [1:0]        mem_result_sel,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_load_data,
  input  logic [XLEN-1:0]   mem_pc_plus4,
  input  logic [XLEN-1:0]   mem_imm,
  input  logic [2:0]        mem_load_fmt,
  input  logic [REG_AW-1:0] read_reg_num1,
  input  logic [REG_AW-1:0] read_reg_num2,
  output logic [REG_AW-1:0] write_reg,
  output logic [XLEN-1:0]   write_data,
  output logic              regwrite,
  output logic              wb_valid,
  output logic              wb_load_err,
  output logic              bypass_hit1,
  output logic              bypass_hit2,
  output logic [XLEN-1:0]   bypass_data1,
  output logic [XLEN-1:0]   bypass_data2,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] FMT_LB  = 3'b000;
  localparam logic [2:0] FMT_LH  = 3'b001;
  localparam logic [2:0] FMT_LW  = 3'b010;
  localparam logic [2:0] FMT_LBU = 3'b100;
  localparam logic [2:0] FMT_LHU = 3'b101;

  logic [1:0]      load_off;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_value;
  logic            load_err;
  logic [XLEN-1:0] result_value;
  logic            load_en;
  logic            retire;

  assign load_off = mem_alu_result[1:0];

  // Extract the addressed byte and halfword lanes from the raw memory word.
  always_comb begin
    load_byte = mem_load_data[7:0];
    case (load_off)
      2'd0: load_byte = mem_load_data[7:0];
      2'd1: load_byte = mem_load_data[15:8];
      2'd2: load_byte = mem_load_data[23:16];
      2'd3: load_byte = mem_load_data[31:24];
      default: load_byte = mem_load_data[7:0];
    endcase
    load_half = load_off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load format.
  always_comb begin
    load_value = '0;
    case (mem_load_fmt)
      FMT_LB:  load_value = {{(XLEN-8){load_byte[7]}}, load_byte};
      FMT_LBU: load_value = {{(XLEN-8){1'b0}}, load_byte};
      FMT_LH:  load_value = {{(XLEN-16){load_half[15]}}, load_half};
      FMT_LHU: load_value = {{(XLEN-16){1'b0}}, load_half};
      FMT_LW:  load_value = mem_load_data;
      default: load_value = '0;
    endcase
  end

  // Flag misaligned halfword/word loads and reserved load encodings.
  always_comb begin
    load_err = 1'b0;
    if (mem_valid && (mem_result_sel == SEL_LOAD)) begin
      case (mem_load_fmt)
        FMT_LB, FMT_LBU: load_err = 1'b0;
        FMT_LH, FMT_LHU: load_err = load_off[0];
        FMT_LW:          load_err = (load_off != 2'd0);
        default:         load_err = 1'b1;
      endcase
    end
  end

  // Writeback value mux; a faulting load writes zero.
  always_comb begin
    result_value = '0;
    case (mem_result_sel)
      SEL_ALU:  result_value = mem_alu_result;
      SEL_LOAD: result_value = load_value;
      SEL_LINK: result_value = mem_pc_plus4;
      SEL_IMM:  result_value = mem_imm;
      default:  result_value = '0;
    endcase
    if (load_err) begin
      result_value = '0;
    end
  end

  assign load_en = !wb_flush && !wb_stall;
  assign retire  = load_en && mem_valid && !load_err;

  // MEM/WB register: flush beats stall, stall beats load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_reg   <= '0;
      write_data  <= '0;
      regwrite    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_load_err <= 1'b0;
    end else if (wb_flush) begin
      // write_reg/write_data hold; they are meaningless while regwrite=0.
      regwrite    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_load_err <= 1'b0;
    end else if (!wb_stall) begin
      write_reg   <= mem_rd;
      write_data  <= result_value;
      regwrite    <= mem_valid && mem_regwrite && (mem_rd != '0) && !load_err;
      wb_valid    <= mem_valid;
      wb_load_err <= load_err;
    end
  end

`ifdef INSTRET_COUNT_EN
  logic [CNT_W-1:0] instret_q;

  // Count instructions that actually enter WB without a load fault.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instret       = '0;
`endif

  // Same-cycle bypass to ID; x0 never hits.
  always_comb begin
    bypass_hit1  = regwrite && (read_reg_num1 == write_reg) && (read_reg_num1 != '0);
    bypass_hit2  = regwrite && (read_reg_num2 == write_reg) && (read_reg_num2 != '0);
    bypass_data1 = bypass_hit1 ? write_data : '0;
    bypass_data2 = bypass_hit2 ? write_data : '0;
  end

endmodule

// File: tb/tb_datapath_wb.sv
// tb_datapath_wb: directed cases plus a randomized stream checked against
// a behavioural writeback model.
module tb_datapath_wb;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 64;

  logic              clock;
  logic              reset;
  logic              mem_valid;
  logic              wb_stall;
  logic              wb_flush;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [1:0]        mem_result_sel;
  logic [XLEN-1:0]   mem_alu_result;
  logic [XLEN-1:0]   mem_load_data;
  logic [XLEN-1:0]   mem_pc_plus4;
  logic [XLEN-1:0]   mem_imm;
  logic [2:0]        mem_load_fmt;
  logic [REG_AW-1:0] read_reg_num1;
  logic [REG_AW-1:0] read_reg_num2;
  logic [REG_AW-1:0] write_reg;
  logic [XLEN-1:0]   write_data;
  logic              regwrite;
  logic              wb_valid;
  logic              wb_load_err;
  logic              bypass_hit1;
  logic              bypass_hit2;
  logic [XLEN-1:0]   bypass_data1;
  logic [XLEN-1:0]   bypass_data2;
  logic [CNT_W-1:0]  instret;

  datapath_wb #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .wb_stall       (wb_stall),
    .wb_flush       (wb_flush),
    .mem_rd         (mem_rd),
    .mem_regwrite   (mem_regwrite),
    .mem_result_sel (mem_result_sel),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_imm        (mem_imm),
    .mem_load_fmt   (mem_load_fmt),
    .read_reg_num1  (read_reg_num1),
    .read_reg_num2  (read_reg_num2),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .regwrite       (regwrite),
    .wb_valid       (wb_valid),
    .wb_load_err    (wb_load_err),
    .bypass_hit1    (bypass_hit1),
    .bypass_hit2    (bypass_hit2),
    .bypass_data1   (bypass_data1),
    .bypass_data2   (bypass_data2),
    .instret        (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the WB stage.
  logic        m_valid;
  logic        m_we;
  logic        m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_known;
  logic [63:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Writeback value from the instruction-set rules, using shifts and masks.
  function automatic logic [31:0] ref_result(output logic err);
    int unsigned off;
    logic [31:0] b, h, res;
    off = mem_alu_result % 4;
    b   = (mem_load_data >> (8 * off)) & 32'hFF;
    h   = (mem_load_data >> (16 * (off / 2))) & 32'hFFFF;
    err = 1'b0;
    res = 32'd0;
    case (mem_result_sel)
      2'd0: res = mem_alu_result;
      2'd2: res = mem_pc_plus4;
      2'd3: res = mem_imm;
      default: begin
        case (mem_load_fmt)
          3'd0: res = (b >= 128) ? b - 32'd256 : b;
          3'd4: res = b;
          3'd1: begin res = (h >= 32768) ? h - 32'd65536 : h; err = (off % 2) != 0; end
          3'd5: begin res = h; err = (off % 2) != 0; end
          3'd2: begin res = mem_load_data; err = (off != 0); end
          default: err = 1'b1;
        endcase
      end
    endcase
    if (!mem_valid) err = 1'b0;
    if (err) res = 32'd0;
    return res;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_err = 0; m_rd = 0; m_data = 0; m_known = 1; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic e;
    logic [31:0] r;
    if (wb_flush) begin
      m_valid = 0; m_we = 0; m_err = 0; m_known = 0;
    end else if (!wb_stall) begin
      r = ref_result(e);
      m_valid = mem_valid;
      m_rd    = mem_rd;
      m_data  = r;
      m_err   = e;
      m_we    = mem_valid && mem_regwrite && (mem_rd != 0) && !e;
      m_known = 1;
      if (mem_valid && !e) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_all();
    logic h1, h2;
    h1 = m_we && (read_reg_num1 == m_rd) && (read_reg_num1 != 0);
    h2 = m_we && (read_reg_num2 == m_rd) && (read_reg_num2 != 0);
    check("wb_valid", 64'(wb_valid), 64'(m_valid));
    check("regwrite", 64'(regwrite), 64'(m_we));
    check("wb_load_err", 64'(wb_load_err), 64'(m_err));
    if (m_known) begin
      check("write_reg", 64'(write_reg), 64'(m_rd));
      check("write_data", 64'(write_data), 64'(m_data));
    end
    check("bypass_hit1", 64'(bypass_hit1), 64'(h1));
    check("bypass_hit2", 64'(bypass_hit2), 64'(h2));
    check("bypass_data1", 64'(bypass_data1), h1 ? 64'(m_data) : 64'd0);
    check("bypass_data2", 64'(bypass_data2), h2 ? 64'(m_data) : 64'd0);
`ifdef INSTRET_COUNT_EN
    check("instret", instret, m_cnt);
`else
    check("instret", instret, 64'd0);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic set_inst(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] fmt);
    mem_valid = v; mem_rd = rd; mem_regwrite = we; mem_result_sel = sel;
    mem_alu_result = alu; mem_load_data = ld; mem_load_fmt = fmt;
    wb_stall = 0; wb_flush = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_write_reg", 64'(write_reg), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_regwrite", 64'(regwrite), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_load_err", 64'(wb_load_err), 64'd0);
    check("rst_instret", instret, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [4:0]  held_rd;
  logic [31:0] held_data;

  initial begin
    reset = 1'b1;
    set_inst(0, 0, 0, 2'd0, 0, 0, 3'd0);
    mem_pc_plus4 = 0; mem_imm = 0; read_reg_num1 = 0; read_reg_num2 = 0;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // ALU result writeback and bypass on port 1.
    set_inst(1, 5'd5, 1, 2'd0, 32'h1234, 32'h0, 3'd0);
    read_reg_num1 = 5'd5; read_reg_num2 = 5'd9;
    step();
    check("t2_write_reg", 64'(write_reg), 64'd5);
    check("t2_write_data", 64'(write_data), 64'h1234);
    check("t2_regwrite", 64'(regwrite), 64'd1);
    check("t2_hit1", 64'(bypass_hit1), 64'd1);
    check("t2_data1", 64'(bypass_data1), 64'h1234);

    // Reset mid-stream while regwrite=1: outputs clear before the next edge.
    #3;
    do_reset();

    // Load alignment cases.
    read_reg_num1 = 5'd6; read_reg_num2 = 5'd0;
    set_inst(1, 5'd6, 1, 2'd1, 32'h3, 32'h80FF7F01, 3'd0);
    step();
    check("t3_lb", 64'(write_data), 64'hFFFFFF80);
    set_inst(1, 5'd6, 1, 2'd1, 32'h2, 32'h80FF7F01, 3'd5);
    step();
    check("t3_lhu", 64'(write_data), 64'h000080FF);
    set_inst(1, 5'd6, 1, 2'd1, 32'h1, 32'h80FF7F01, 3'd1);
    step();
    check("t3_lh_err", 64'(wb_load_err), 64'd1);
    check("t3_lh_we", 64'(regwrite), 64'd0);

    // x0 is never written nor bypassed.
    set_inst(1, 5'd0, 1, 2'd0, 32'hDEAD, 32'h0, 3'd0);
    read_reg_num2 = 5'd0;
    step();
    check("t4_we_x0", 64'(regwrite), 64'd0);
    check("t4_hit2_x0", 64'(bypass_hit2), 64'd0);

    // Stall holds everything for three cycles, then stall+flush bubbles.
    set_inst(1, 5'd7, 1, 2'd0, 32'hAAAA, 32'h0, 3'd0);
    read_reg_num1 = 5'd7;
    step();
    held_rd = write_reg; held_data = write_data;
    for (int i = 0; i < 3; i++) begin
      set_inst(1, 5'($urandom_range(1, 31)), 1, 2'd0, $urandom, 32'h0, 3'd0);
      wb_stall = 1;
      step();
      check("t5_stall_rd", 64'(write_reg), 64'(held_rd));
      check("t5_stall_data", 64'(write_data), 64'(held_data));
      check("t5_stall_we", 64'(regwrite), 64'd1);
    end
    wb_stall = 1; wb_flush = 1;
    step();
    check("t5_flush_valid", 64'(wb_valid), 64'd0);
    check("t5_flush_we", 64'(regwrite), 64'd0);

    // Randomized stream against the model.
    for (int i = 0; i < 400; i++) begin
      mem_valid      = ($urandom_range(0, 9) != 0);
      mem_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mem_regwrite   = ($urandom_range(0, 4) != 0);
      mem_result_sel = 2'($urandom_range(0, 3));
      mem_alu_result = $urandom;
      mem_load_data  = $urandom;
      mem_pc_plus4   = $urandom;
      mem_imm        = $urandom;
      mem_load_fmt   = 3'($urandom_range(0, 7));
      wb_stall       = ($urandom_range(0, 9) == 0);
      wb_flush       = ($urandom_range(0, 19) == 0);
      read_reg_num1  = $urandom_range(0, 1) ? m_rd : 5'($urandom_range(0, 31));
      read_reg_num2  = $urandom_range(0, 1) ? m_rd : 5'($urandom_range(0, 31));
      step();
    end

    // Retire counting: 9 good, 1 misaligned LW, 2 stalls and 1 flush.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_inst(1, 5'(i + 1), 1, 2'd0, 32'(i), 32'h0, 3'd0);
      if (i == 3 || i == 8) wb_stall = 1;
      if (i == 5) wb_flush = 1;
      if (i == 10) set_inst(1, 5'd3, 1, 2'd1, 32'h2, 32'h11223344, 3'd2);
      step();
    end
`ifdef INSTRET_COUNT_EN
    check("t6_instret", instret, 64'd9);
`else
    check("t6_instret", instret, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
